// File: rtl/fc_core_feeder.sv
// fc_core_feeder: sequences one fully-connected MAC core for a single output
// neuron. On start it pulses the core clear, streams N (node, weight) pairs out
// of two 1-latency RAMs, adds the bias on the first beat only, then captures the
// core's accumulated result once the last beat's core valid comes back.
// Optional feature macro: FC_RELU_EN clamps negative captured results to zero.
//
// Core interface: there is no ready. The core must accept a beat in every
// cycle o_core_valid is high, and it reports each accepted beat with one
// i_core_valid pulse exactly one cycle later.
module fc_core_feeder #(
  parameter int IN_DATA_WIDTH = 8,
  parameter int WGT_WIDTH     = 9,
  parameter int ADDR_WIDTH    = 10
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       i_start,
  input  logic [ADDR_WIDTH-1:0]      i_num_in,
  input  logic [IN_DATA_WIDTH-1:0]   i_bias,
  output logic                       o_idle,
  output logic                       o_done,
  output logic                       o_node_ce,
  output logic [ADDR_WIDTH-1:0]      o_node_addr,
  input  logic [IN_DATA_WIDTH-1:0]   i_node_q,
  output logic                       o_wegt_ce,
  output logic [ADDR_WIDTH-1:0]      o_wegt_addr,
  input  logic [WGT_WIDTH-1:0]       i_wegt_q,
  output logic                       o_core_run,
  output logic                       o_core_valid,
  output logic [IN_DATA_WIDTH-1:0]   o_core_node,
  output logic [WGT_WIDTH-1:0]       o_core_wegt,
  output logic [IN_DATA_WIDTH-1:0]   o_core_bias,
  input  logic                       i_core_valid,
  input  logic [4*IN_DATA_WIDTH-1:0] i_core_result,
  output logic [4*IN_DATA_WIDTH-1:0] o_result,
  output logic                       o_result_valid,
  output logic [2:0]                 o_dbg_state
);

  localparam int DW = IN_DATA_WIDTH;
  localparam int AW = ADDR_WIDTH;
  localparam int RW = 4 * IN_DATA_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_FEED  = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   n_q;          // latched node count
  logic [DW-1:0]   bias_q;       // latched bias
  logic [AW-1:0]   addr_q;       // next read address while feeding
  logic [AW-1:0]   beats_q;      // core valid pulses seen since CLEAR
  logic            ce_d;         // read enable delayed to line up with RAM data
  logic            first_d;      // the beat now on the core is beat 0
  logic [RW-1:0]   result_q;
  logic            ce;
  logic            last_beat;
  logic [RW-1:0]   captured;

  // A read is issued in CLEAR (address 0) when N>0, and in every FEED cycle.
  assign ce        = ((state_q == S_CLEAR) && (n_q != '0)) || (state_q == S_FEED);
  assign last_beat = i_core_valid && ((beats_q + AW'(1)) == n_q);

  // Value to store when the final result arrives, optionally ReLU-clamped.
  always_comb begin
    captured = i_core_result;
`ifdef FC_RELU_EN
    if (i_core_result[RW-1]) captured = '0;
`endif
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic: CLEAR picks FEED/WAIT/DONE depending on how many reads remain.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (i_start) state_d = S_CLEAR;
      S_CLEAR: begin
        if (n_q == '0)           state_d = S_DONE;
        else if (n_q == AW'(1))  state_d = S_WAIT;
        else                     state_d = S_FEED;
      end
      S_FEED:  if (addr_q == (n_q - AW'(1))) state_d = S_WAIT;
      S_WAIT:  if (last_beat) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Job parameters, address and beat counters, beat alignment and result capture.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      n_q      <= '0;
      bias_q   <= '0;
      addr_q   <= '0;
      beats_q  <= '0;
      ce_d     <= 1'b0;
      first_d  <= 1'b0;
      result_q <= '0;
    end else begin
      ce_d    <= ce;
      first_d <= (state_q == S_CLEAR) && ce;
      if ((state_q == S_IDLE) && i_start) begin
        n_q    <= i_num_in;
        bias_q <= i_bias;
      end
      if (state_q == S_CLEAR)     addr_q <= AW'(1);
      else if (state_q == S_FEED) addr_q <= addr_q + AW'(1);
      if (state_q == S_CLEAR) beats_q <= '0;
      else if (((state_q == S_FEED) || (state_q == S_WAIT)) && i_core_valid)
        beats_q <= beats_q + AW'(1);
      if ((state_q == S_CLEAR) && (n_q == '0)) result_q <= '0;
      else if ((state_q == S_WAIT) && last_beat) result_q <= captured;
    end
  end

  assign o_idle         = (state_q == S_IDLE);
  assign o_done         = (state_q == S_DONE);
  assign o_result_valid = (state_q == S_DONE);
  assign o_core_run     = (state_q == S_CLEAR);
  assign o_node_ce      = ce;
  assign o_wegt_ce      = ce;
  assign o_node_addr    = (state_q == S_FEED) ? addr_q : '0;
  assign o_wegt_addr    = o_node_addr;
  assign o_core_valid   = ce_d;
  assign o_core_node    = i_node_q;
  assign o_core_wegt    = i_wegt_q;
  assign o_core_bias    = first_d ? bias_q : '0;
  assign o_result       = result_q;
  assign o_dbg_state    = state_q;

endmodule
